// File: rtl/t03_mem_sequencer.sv
// Single-port bus sequencer arbitrating core instruction fetches and data loads/stores.
// One transaction at a time: IDLE -> REQ -> WAIT -> DONE, with misaligned/reserved data accesses short-circuited to DONE.
module t03_mem_sequencer (
  input  logic        clk,
  input  logic        nRst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  dataWidth,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic [31:0] instr,
  output logic        i_ack,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        freeze
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  width_q, width_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] drdata_q, drdata_d;

  logic        dataReq;
  logic [3:0]  dSel;
  logic [31:0] dWdata;
  logic        dErr;
  logic [31:0] shifted;
  logic [31:0] loadData;
  logic        busActive;

  assign dataReq = d_read | d_write;

  // Lane select, replicated store data and legality of the incoming data request.
  always_comb begin
    dSel   = 4'b1111;
    dWdata = d_wdata;
    dErr   = 1'b0;
    case (dataWidth)
      3'b000, 3'b100: begin
        dSel   = 4'b0001 << d_addr[1:0];
        dWdata = {4{d_wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        dSel   = 4'b0011 << {d_addr[1], 1'b0};
        dWdata = {2{d_wdata[15:0]}};
        dErr   = d_addr[0];
      end
      3'b010: begin
        dErr = |d_addr[1:0];
      end
      default: begin
        dSel = 4'b0000;
        dErr = 1'b1;
      end
    endcase
  end

  always_comb begin
    shifted  = bus_rdata >> {addr_q[1:0], 3'b000};
    loadData = shifted;
    case (width_q)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadData = {24'd0, shifted[7:0]};
      3'b101:  loadData = {16'd0, shifted[15:0]};
      default: loadData = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    width_d  = width_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    instr_d  = instr_q;
    drdata_d = drdata_q;
    case (state_q)
      IDLE: begin
        if (dataReq) begin
          owner_d = OWN_DATA;
          addr_d  = d_addr;
          width_d = dataWidth;
          sel_d   = dSel;
          wdata_d = dWdata;
          write_d = d_write;
          err_d   = dErr;
          if (dErr) begin
            drdata_d = 32'd0;
            state_d  = DONE;
          end else begin
            state_d = REQ;
          end
        end else if (i_req) begin
          owner_d = OWN_FETCH;
          addr_d  = i_addr;
          width_d = 3'b010;
          sel_d   = 4'b1111;
          wdata_d = 32'd0;
          write_d = 1'b0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (!bus_busy) begin
          state_d = DONE;
          if (owner_q == OWN_FETCH) begin
            instr_d = bus_rdata;
          end else if (!write_q) begin
            drdata_d = loadData;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_FETCH;
      addr_q   <= 32'd0;
      width_q  <= 3'd0;
      sel_q    <= 4'd0;
      wdata_q  <= 32'd0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      instr_q  <= 32'd0;
      drdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      instr_q  <= instr_d;
      drdata_q <= drdata_d;
    end
  end

  assign busActive = (state_q == REQ) || (state_q == WAIT);
  assign bus_read  = (state_q == REQ) && !write_q;
  assign bus_write = (state_q == REQ) && write_q;
  assign bus_addr  = busActive ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus_sel   = busActive ? sel_q : 4'd0;
  assign bus_wdata = (busActive && write_q) ? wdata_q : 32'd0;
  assign instr     = instr_q;
  assign d_rdata   = drdata_q;
  assign i_ack     = (state_q == DONE) && (owner_q == OWN_FETCH);
  assign d_ack     = (state_q == DONE) && (owner_q == OWN_DATA);
  assign d_err     = d_ack && err_q;
  // Gated by nRst so that every output reads 0 while reset is held, even with a request pending.
  assign freeze    = nRst & ((dataReq & ~d_ack) | ((state_q != IDLE) & (owner_q == OWN_DATA)));

endmodule

// File: tb/tb_t03_mem_sequencer.sv
// Directed self-checking bench for t03_mem_sequencer: fetch, loads, stores, arbitration,
// misalignment and asynchronous reset mid-transaction, with hand-computed expectations.
module tb_t03_mem_sequencer;

  logic        clk = 1'b0;
  logic        nRst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  dataWidth;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_busy;
  logic [31:0] instr;
  logic        i_ack;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        freeze;

  int checkCount = 0;
  int errorCount = 0;

  t03_mem_sequencer dut (
    .clk(clk), .nRst(nRst),
    .i_req(i_req), .i_addr(i_addr),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .dataWidth(dataWidth),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_rdata(bus_rdata), .bus_busy(bus_busy),
    .instr(instr), .i_ack(i_ack), .d_rdata(d_rdata),
    .d_ack(d_ack), .d_err(d_err), .freeze(freeze)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dRead,
                               input logic dWrite, input logic [31:0] dAddr,
                               input logic [31:0] dWdata, input logic [2:0] width);
    i_req     = iReq;
    i_addr    = iAddr;
    d_read    = dRead;
    d_write   = dWrite;
    d_addr    = dAddr;
    d_wdata   = dWdata;
    dataWidth = width;
  endtask

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic byteLoad(input logic [2:0] width, input logic [31:0] expData, input string tag);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h203, 32'd0, width);
    bus_rdata = 32'h80FFFFFF;
    #1;
    checkOutput({tag, " freeze on request"}, {31'd0, freeze}, 32'd1);
    stepCycle();
    checkOutput({tag, " bus_read"}, {31'd0, bus_read}, 32'd1);
    checkOutput({tag, " bus_sel"}, {28'd0, bus_sel}, 32'h8);
    checkOutput({tag, " bus_addr"}, bus_addr, 32'h200);
    stepCycle();
    stepCycle();
    checkOutput({tag, " d_ack"}, {31'd0, d_ack}, 32'd1);
    checkOutput({tag, " d_err"}, {31'd0, d_err}, 32'd0);
    checkOutput({tag, " d_rdata"}, d_rdata, expData);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    stepCycle();
    checkOutput({tag, " d_ack drop"}, {31'd0, d_ack}, 32'd0);
    checkOutput({tag, " freeze drop"}, {31'd0, freeze}, 32'd0);
  endtask

  task automatic badAccess(input logic [31:0] addr, input logic [2:0] width, input string tag);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, addr, 32'd0, width);
    stepCycle();
    checkOutput({tag, " d_ack"}, {31'd0, d_ack}, 32'd1);
    checkOutput({tag, " d_err"}, {31'd0, d_err}, 32'd1);
    checkOutput({tag, " d_rdata"}, d_rdata, 32'd0);
    checkOutput({tag, " no strobe"}, {30'd0, bus_read, bus_write}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    stepCycle();
    checkOutput({tag, " d_err drop"}, {31'd0, d_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nRst = 1'b0;
    bus_rdata = 32'd0;
    bus_busy = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    stepCycle();
    stepCycle();
    checkOutput("reset outputs", {bus_read, bus_write, i_ack, d_ack, d_err, freeze, 26'd0}, 32'd0);
    checkOutput("reset instr", instr, 32'd0);
    checkOutput("reset bus_sel", {28'd0, bus_sel}, 32'd0);

    // Fetch accepted on the first edge after release.
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    bus_rdata = 32'h00500093;
    nRst = 1'b1;
    stepCycle();
    checkOutput("fetch bus_read", {31'd0, bus_read}, 32'd1);
    checkOutput("fetch bus_write", {31'd0, bus_write}, 32'd0);
    checkOutput("fetch bus_addr", bus_addr, 32'h100);
    checkOutput("fetch bus_sel", {28'd0, bus_sel}, 32'hF);
    stepCycle();
    checkOutput("fetch wait strobe", {31'd0, bus_read}, 32'd0);
    checkOutput("fetch wait addr", bus_addr, 32'h100);
    checkOutput("fetch early ack", {31'd0, i_ack}, 32'd0);
    stepCycle();
    checkOutput("fetch i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("fetch instr", instr, 32'h00500093);
    checkOutput("fetch no d_ack", {31'd0, d_ack}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    stepCycle();
    checkOutput("fetch ack drop", {31'd0, i_ack}, 32'd0);

    byteLoad(3'b000, 32'hFFFFFF80, "lb");
    byteLoad(3'b100, 32'h00000080, "lbu");
    checkOutput("instr held", instr, 32'h00500093);

    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h302, 32'h1234ABCD, 3'b001);
    bus_rdata = 32'h55555555;
    stepCycle();
    checkOutput("sh bus_write", {31'd0, bus_write}, 32'd1);
    checkOutput("sh bus_read", {31'd0, bus_read}, 32'd0);
    checkOutput("sh bus_sel", {28'd0, bus_sel}, 32'hC);
    checkOutput("sh bus_wdata", bus_wdata, 32'hABCDABCD);
    checkOutput("sh freeze req", {31'd0, freeze}, 32'd1);
    stepCycle();
    checkOutput("sh wait wdata", bus_wdata, 32'hABCDABCD);
    checkOutput("sh wait strobe", {31'd0, bus_write}, 32'd0);
    checkOutput("sh freeze wait", {31'd0, freeze}, 32'd1);
    stepCycle();
    checkOutput("sh d_ack", {31'd0, d_ack}, 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    stepCycle();
    checkOutput("sh freeze drop", {31'd0, freeze}, 32'd0);

    // Data wins over fetch; three busy WAIT cycles delay d_ack to N+6.
    applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'd0, 3'b010);
    bus_rdata = 32'hCAFEF00D;
    bus_busy = 1'b1;
    stepCycle();
    checkOutput("conflict data first", {31'd0, bus_read}, 32'd1);
    checkOutput("conflict addr", bus_addr, 32'h500);
    for (int k = 2; k <= 5; k++) begin
      stepCycle();
      checkOutput("conflict early ack", {30'd0, d_ack, i_ack}, 32'd0);
      if (k == 5) bus_busy = 1'b0;
    end
    stepCycle();
    checkOutput("conflict d_ack N+6", {31'd0, d_ack}, 32'd1);
    checkOutput("conflict d_rdata", d_rdata, 32'hCAFEF00D);
    applyStimulus(1'b1, 32'h400, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    bus_rdata = 32'h11112222;
    stepCycle();
    checkOutput("conflict idle gap", {31'd0, bus_read}, 32'd0);
    stepCycle();
    checkOutput("conflict fetch strobe", {31'd0, bus_read}, 32'd1);
    checkOutput("conflict fetch addr", bus_addr, 32'h400);
    stepCycle();
    stepCycle();
    checkOutput("conflict i_ack", {31'd0, i_ack}, 32'd1);
    checkOutput("conflict instr", instr, 32'h11112222);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    stepCycle();

    badAccess(32'h401, 3'b010, "misaligned lw");
    badAccess(32'h601, 3'b001, "misaligned lh");
    badAccess(32'h600, 3'b011, "reserved code");

    // Asynchronous reset while the fetch sits in WAIT.
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    bus_busy = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("pre-reset wait addr", bus_addr, 32'h700);
    nRst = 1'b0;
    #1;
    checkOutput("async reset addr", bus_addr, 32'd0);
    checkOutput("async reset sel", {28'd0, bus_sel}, 32'd0);
    checkOutput("async reset instr", instr, 32'd0);
    checkOutput("async reset flags", {bus_read, bus_write, i_ack, d_ack, d_err, freeze, 26'd0}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    bus_busy = 1'b0;
    stepCycle();
    nRst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      stepCycle();
      checkOutput("no ack after abort", {30'd0, i_ack, d_ack}, 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'h800, 32'd0, 3'b010);
    bus_rdata = 32'h0BADBEEF;
    stepCycle();
    checkOutput("post-reset strobe", {31'd0, bus_read}, 32'd1);
    stepCycle();
    stepCycle();
    checkOutput("post-reset d_ack", {31'd0, d_ack}, 32'd1);
    checkOutput("post-reset d_rdata", d_rdata, 32'h0BADBEEF);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
